// File: rtl/ring_counter_ctrl_if.sv
// ring_counter_ctrl_if: command and ring-output bundle between board control and ring_counter_ctrl
interface ring_counter_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
);
    logic                     start;
    logic                     stop;
    logic                     step;
    logic                     mode;
    logic                     dir;
    logic [DWELL_W-1:0]       dwell;
    logic [7:0]               burst_len;
    logic [WIDTH-1:0]         T;
    logic [$clog2(WIDTH)-1:0] pos;
    logic                     busy;
    logic                     done;
    logic                     wrap;

    modport master (
        output start, stop, step, mode, dir, dwell, burst_len,
        input  T, pos, busy, done, wrap
    );

    modport slave (
        input  start, stop, step, mode, dir, dwell, burst_len,
        output T, pos, busy, done, wrap
    );
endinterface

// File: rtl/ring_counter_ctrl.sv
// ring_counter_ctrl: one-hot ring sequencer (free-run/burst/step, dwell); RING_COUNTER_CTRL_WRAP_EN enables wrap pulse
module ring_counter_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input logic              clk,
    input logic              rst,
    ring_counter_ctrl_if.slave bus
);
    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] PMAX = PW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

    state_t             state;
    logic [WIDTH-1:0]   t;
    logic [WIDTH-1:0]   t_nxt;
    logic [PW-1:0]      pos;
    logic [PW-1:0]      pos_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         rem;
    logic               dir_q;
    logic               busy;
    logic               done;
    logic               adv_dir;
    logic               due;
    logic               adv;
`ifdef RING_COUNTER_CTRL_WRAP_EN
    logic               wrap_hit;
    logic               wrap_q;
`endif

    always_comb begin
        adv_dir = (state == IDLE) ? bus.dir : dir_q;
        due     = cnt == dwell_q;
        adv     = (state == IDLE) ? (!bus.stop && !bus.start && bus.step) : (!bus.stop && due);
        t_nxt   = adv_dir ? {t[0], t[WIDTH-1:1]} : {t[WIDTH-2:0], t[WIDTH-1]};
        pos_nxt = adv_dir ? ((pos == '0) ? PMAX : pos - 1'b1) : ((pos == PMAX) ? '0 : pos + 1'b1);
`ifdef RING_COUNTER_CTRL_WRAP_EN
        wrap_hit = adv_dir ? (pos == '0) : (pos == PMAX);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            t       <= WIDTH'(1);
            pos     <= '0;
            cnt     <= '0;
            dwell_q <= '0;
            rem     <= '0;
            dir_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef RING_COUNTER_CTRL_WRAP_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef RING_COUNTER_CTRL_WRAP_EN
            wrap_q <= adv && wrap_hit;
`endif
            if (adv) begin
                t   <= t_nxt;
                pos <= pos_nxt;
            end
            if (state == IDLE) begin
                if (!bus.stop && bus.start) begin
                    dir_q   <= bus.dir;
                    dwell_q <= bus.dwell;
                    rem     <= bus.burst_len;
                    cnt     <= '0;
                    if (!bus.mode) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end else if (bus.burst_len != 8'd0) begin
                        state <= BURST;
                        busy  <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else if (bus.stop) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (due) begin
                cnt <= '0;
                if (state == BURST) begin
                    rem <= rem - 8'd1;
                    if (rem == 8'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.T    = t;
    assign bus.pos  = pos;
    assign bus.busy = busy;
    assign bus.done = done;
`ifdef RING_COUNTER_CTRL_WRAP_EN
    assign bus.wrap = wrap_q;
`else
    assign bus.wrap = 1'b0;
`endif
endmodule

// File: tb/tb_ring_counter_ctrl.sv
// tb_ring_counter_ctrl: directed self-checking bench for ring_counter_ctrl
module tb_ring_counter_ctrl;
`ifdef RING_COUNTER_CTRL_WRAP_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ring_counter_ctrl_if #(.WIDTH(8), .DWELL_W(16)) bus ();

    ring_counter_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic state_is(input string tag, input logic [7:0] t, input logic [2:0] p,
                            input logic b, input logic d, input logic w);
        check({tag, ".T"}, 32'(bus.T), 32'(t));
        check({tag, ".pos"}, 32'(bus.pos), 32'(p));
        check({tag, ".busy"}, 32'(bus.busy), 32'(b));
        check({tag, ".done"}, 32'(bus.done), 32'(d));
        check({tag, ".wrap"}, 32'(bus.wrap), 32'(w));
    endtask

    task automatic go(input logic m, input logic d, input logic [15:0] dw, input logic [7:0] bl);
        bus.start = 1'b1; bus.mode = m; bus.dir = d; bus.dwell = dw; bus.burst_len = bl;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic halt();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.mode = 1'b0;
        bus.dir = 1'b0; bus.dwell = '0; bus.burst_len = '0;
        #12 rst = 1'b0;
        state_is("reset", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);

        // stop beats start in IDLE
        bus.stop = 1'b1;
        go(1'b0, 1'b0, 16'd0, 8'd0);
        bus.stop = 1'b0;
        state_is("idle_stop", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);

        // free-run, dir=0, dwell=0
        go(1'b0, 1'b0, 16'd0, 8'd0);
        state_is("run_k", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            state_is($sformatf("run%0d", i), 8'(1 << (i % 8)), 3'(i % 8), 1'b1, 1'b0, WE && (i == 8));
        end
        halt();
        state_is("run_stop", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);

        // burst dir=1 dwell=2 len=3
        go(1'b1, 1'b1, 16'd2, 8'd3);
        state_is("b_k", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        state_is("b_k2", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        state_is("b_k3", 8'h80, 3'd7, 1'b1, 1'b0, WE);
        tick(); tick(); tick();
        state_is("b_k6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        state_is("b_k9", 8'h20, 3'd5, 1'b0, 1'b1, 1'b0);
        tick();
        state_is("b_k10", 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);

        // stop on the edge an advance is due
        go(1'b0, 1'b0, 16'd1, 8'd0);
        tick();
        state_is("s_k1", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0);
        halt();
        state_is("s_stop", 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
        tick();
        state_is("s_after", 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
        go(1'b0, 1'b0, 16'd0, 8'd0);
        tick();
        state_is("s_resume", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
        halt();
        state_is("s_stop2", 8'h40, 3'd6, 1'b0, 1'b0, 1'b0);

        // async reset to bring T back to 01, then IDLE step
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        state_is("rst2", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
        bus.step = 1'b1; bus.dir = 1'b0;
        tick();
        bus.step = 1'b0;
        state_is("step", 8'h02, 3'd1, 1'b0, 1'b0, 1'b0);

        // run with dwell=3; start/step/settings pulsed while busy are ignored
        go(1'b0, 1'b0, 16'd3, 8'd0);
        tick();
        bus.start = 1'b1; bus.step = 1'b1; bus.dir = 1'b1; bus.dwell = 16'd0;
        bus.mode = 1'b1; bus.burst_len = 8'd1;
        tick();
        bus.start = 1'b0; bus.step = 1'b0;
        state_is("ign_k2", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        state_is("ign_k3", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        state_is("ign_k4", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        state_is("ign_k7", 8'h04, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        state_is("ign_k8", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
        halt();
        state_is("ign_stop", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);

        // burst_len=0
        go(1'b1, 1'b0, 16'd0, 8'd0);
        state_is("bl0", 8'h08, 3'd3, 1'b0, 1'b1, 1'b0);
        tick();
        state_is("bl0_next", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);

        // reset mid-burst
        go(1'b1, 1'b0, 16'd0, 8'd5);
        tick();
        state_is("mb_k1", 8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        state_is("mb_rst", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        state_is("mb_after", 8'h01, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ring_counter_ctrl.md
# ring_counter_ctrl

Sequencing controller for the one-hot ring counter datapath. It owns the ring register `T` and advances it under command control: free-run, fixed-length burst, or single-step, in either direction. A programmable dwell count sets how many cycles each position is held. It sits between the board-level control logic (buttons or FSM) and the LED/phase outputs that consume `T`.

## Interface
- `WIDTH`, 8: ring length in bits; must be ≥2.
- `DWELL_W`, 16: width of the dwell counter and the `dwell` input.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: **asynchronous, active-high reset**.
- `start` input 1: begin a run or burst; sampled only in IDLE.
- `stop` input 1: abort a run or burst; returns to IDLE.
- `step` input 1: advance one position; sampled only in IDLE.
- `mode` input 1: 0 = free-run, 1 = burst; captured on an accepted start.
- `dir` input 1: 0 = rotate toward MSB, 1 = rotate toward LSB; captured on start, and sampled directly for step.
- `dwell` input DWELL_W: extra hold cycles per position; captured on start.
- `burst_len` input 8: number of advances in burst mode; captured on start.
- `T` output WIDTH: one-hot ring value.
- `pos` output $clog2(WIDTH): index of the set bit in `T`.
- `busy` output 1: high in RUN or BURST.
- `done` output 1: one-cycle pulse when a burst completes.
- `wrap` output 1: one-cycle wrap pulse; see Configuration.

## Operation
- Reset values:
  - `T` = 1 (bit 0), `pos` = 0.
  - `busy`, `done`, `wrap` = 0.
  - State = IDLE; dwell counter and remaining count = 0.
- States:
  - IDLE
  - RUN: free-run mode.
  - BURST: fixed-length mode.
- Advance:
  - dir=0: `T` rotates left (MSB wraps to bit 0); `pos` = (pos+1) mod WIDTH.
  - dir=1: `T` rotates right (bit 0 wraps to MSB); `pos` = (pos−1) mod WIDTH.
- IDLE behaviour:
  - `start` with mode=0 → RUN.
  - `start` with mode=1 and `burst_len`≠0 → BURST, with remaining = `burst_len`.
  - `start` with mode=1 and `burst_len`=0 → stays IDLE; `done` pulses on the next edge; no advance.
  - `step` (without `start`) → one advance on the next edge, using the live `dir`; `busy` stays 0.
- Dwell: a counter runs 0..dwell_captured. An advance occurs on the edge where counter == dwell_captured, and the counter then clears. dwell=0 gives one advance per cycle.
- RUN: advances indefinitely until `stop`.
- BURST: each advance decrements remaining. On the final advance (remaining 1→0), in the same edge:
  - state → IDLE,
  - `busy` → 0,
  - `done` → 1 for one cycle.
- Priority and ignore rules:
  - `stop` beats an advance due in the same cycle: no advance, `T` holds, state → IDLE, no `done`.
  - In IDLE, `stop` beats `start` and `step`; all three are ignored.
  - `start`, `step`, `mode`, `dir`, `dwell` and `burst_len` are ignored while `busy`.
  - `start` and `step` together in IDLE: `start` wins.
- `T` is never cleared by `stop`. It holds its position for the next start.
- Asserting `rst` at any time, including mid-burst, immediately forces the reset values; no `done` is produced.

## Timing
- All outputs are registered; there is no combinational input→output path.
- `start` accepted at edge k:
  - `busy`=1 after edge k.
  - First advance at edge k+dwell+1; later advances every dwell+1 edges.
- Burst of N advances: the final advance, `done`=1 and `busy`=0 all appear after edge k+N·(dwell+1).
- `step` accepted at edge k: `T` changes at edge k.
- `stop` accepted at edge k: `busy`=0 after edge k.
- `wrap` and `done` are high for exactly one cycle and change with the same edge as `T`.

## Configuration
- Macro: `RING_COUNTER_CTRL_WRAP_EN`.
- Defined:
  - `wrap` pulses for one cycle when an advance moves `pos` from WIDTH−1 to 0 (dir=0) or from 0 to WIDTH−1 (dir=1).
  - Steps count as advances.
- Undefined: `wrap` is tied to 0 and the wrap-detect logic is removed.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle during a run → immediately `T`=8'h01, `pos`=0, `busy`=0, `done`=0, `wrap`=0.
- Free-run, dir=0, dwell=0, start at edge k → `T` = 02, 04, 08, …, 80, 01 on successive edges; `wrap`=1 only in the cycle `T`=01 (macro defined); `wrap` stays 0 with the macro undefined.
- Burst, dir=1, dwell=2, burst_len=3, starting from `T`=01 → `T`=80 at k+3, 40 at k+6, 20 at k+9; at k+9 `done`=1 and `busy`=0; `done` is 0 at k+10.
- Stop in the cycle an advance is due (dwell=1) → `T` is unchanged, `busy`=0 next cycle, `done` never asserts; a following start resumes from the held `T`.
- IDLE step, dir=0, `T`=01 → `T`=02 after one edge with `busy`=0; then start a run and pulse `start`/`step` again → no extra advances and captured settings unchanged.
- Burst with burst_len=0 → `done` pulses once, `T` unchanged, `busy` stays 0; then assert `rst` mid-burst (burst_len=5) → reset values and no `done`.
